// File: rtl/systolic_divider.sv
// Bit-serial restoring divider: parallel divisor, serial MSB-first dividend in, serial quotient out.
// Optional synchronous abort input enabled by defining SYSTOLIC_DIVIDER_ABORT_EN.
module systolic_divider #(
    parameter int p_WORD_WIDTH = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    input  logic                    i_START,
    input  logic [p_WORD_WIDTH-1:0] i_DIVISOR,
    input  logic                    i_DIVIDEND,
`ifdef SYSTOLIC_DIVIDER_ABORT_EN
    input  logic                    i_ABORT,
`endif
    output logic                    o_BUSY,
    output logic                    o_QUOTIENT,
    output logic                    o_QUOTIENT_VALID,
    output logic [p_WORD_WIDTH-1:0] o_REMAINDER,
    output logic                    o_DONE,
    output logic                    o_DIV_BY_ZERO
);
    localparam int CNT_W = $clog2(p_WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(p_WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [p_WORD_WIDTH-1:0] divisor;
    logic [p_WORD_WIDTH-1:0] rem;
    logic [p_WORD_WIDTH-1:0] rem_next;
    logic [p_WORD_WIDTH-1:0] remainder;
    logic [p_WORD_WIDTH:0]   partial;
    logic [CNT_W-1:0]        cnt;
    logic                    q_bit;
    logic                    quotient;
    logic                    quotient_valid;
    logic                    div_by_zero;
    logic                    abort;
    logic                    start_ok;
    logic                    last_step;

`ifdef SYSTOLIC_DIVIDER_ABORT_EN
    assign abort = i_ABORT && (state != S_IDLE);
`else
    assign abort = 1'b0;
`endif

    // Abort wins over a coincident start; starts are ignored while RUN is in progress.
    assign start_ok  = i_START && (state != S_RUN) && !abort;
    assign last_step = (state == S_RUN) && (cnt == LAST_CNT);

    // rem < divisor is invariant, so the low W bits of the difference are exact.
    assign partial  = {rem, i_DIVIDEND};
    assign q_bit    = (partial >= {1'b0, divisor});
    assign rem_next = q_bit ? (partial[p_WORD_WIDTH-1:0] - divisor) : partial[p_WORD_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (last_step) state_next = S_DONE;
            S_DONE:  state_next = start_ok ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            divisor        <= '0;
            rem            <= '0;
            cnt            <= '0;
            quotient       <= 1'b0;
            quotient_valid <= 1'b0;
            remainder      <= '0;
            div_by_zero    <= 1'b0;
        end else if (abort) begin
            rem            <= '0;
            cnt            <= '0;
            quotient       <= 1'b0;
            quotient_valid <= 1'b0;
            remainder      <= '0;
            div_by_zero    <= 1'b0;
        end else if (start_ok) begin
            divisor        <= i_DIVISOR;
            rem            <= '0;
            cnt            <= '0;
            quotient       <= 1'b0;
            quotient_valid <= 1'b0;
            div_by_zero    <= (i_DIVISOR == '0);
        end else if (state == S_RUN) begin
            rem            <= rem_next;
            cnt            <= cnt + 1'b1;
            quotient       <= q_bit;
            quotient_valid <= 1'b1;
            if (last_step) remainder <= rem_next;
        end else begin
            quotient       <= 1'b0;
            quotient_valid <= 1'b0;
        end
    end

    assign o_BUSY           = (state == S_RUN);
    assign o_DONE           = (state == S_DONE);
    assign o_QUOTIENT       = quotient;
    assign o_QUOTIENT_VALID = quotient_valid;
    assign o_REMAINDER      = remainder;
    assign o_DIV_BY_ZERO    = div_by_zero;

endmodule
